alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid buffer, 0 = single pipeline register.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port flush, input, 1, discards all buffered and incoming entries.
REQ-005 SHALL have port in_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port in_ready, output, 1, stage accepts instruction this cycle.
REQ-007 SHALL have port instr, input, 32, RV32I instruction word.
REQ-008 SHALL have port pc, input, 32, instruction address.
REQ-009 SHALL have ports rs1_data and rs2_data, input, 32 each, register-file read data.
REQ-010 SHALL have port out_valid, output, 1, issued ALU request valid.
REQ-011 SHALL have port out_ready, input, 1, ALU/execute accepts request.
REQ-012 SHALL have port control, output, 4, common-package ALU_* code.
REQ-013 SHALL have ports left_operand and right_operand, output, 32 each, ALU operands.
REQ-014 SHALL have port rd, output, 5, destination register (instr[11:7]).
REQ-015 SHALL have port illegal, output, 1, opcode/funct not decodable.

Function
REQ-016 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-017 SHALL present a transferred instruction at the outputs exactly 1 cycle after the input transfer when the output register is empty or draining.
REQ-018 SHALL sustain 1 instruction/cycle while out_ready stays high.
REQ-019 SHALL, with SKID_EN=1, drive in_ready = !skid_valid (registered), park the accepted entry in the skid register when out_valid && !out_ready, and refill the output register from the skid register on the next output transfer.
REQ-020 SHALL, with SKID_EN=0, drive in_ready = !out_valid || out_ready.
REQ-021 SHALL keep all output fields stable while out_valid && !out_ready.
REQ-022 SHALL deliver instructions in order with no loss or duplication.
REQ-023 SHALL decode opcode 0110011 (R-type): funct3/funct7[5] → ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; operands rs1_data, rs2_data.
REQ-024 SHALL decode opcode 0010011 (I-type): same mapping, no SUB; SRAI when funct7[5]=1; right = sign-extended instr[31:20] (shifts: zero-extended shamt).
REQ-025 SHALL decode LUI as ADD with left 0 and right {instr[31:12],12'b0}, and AUIPC as ADD with left pc and the same right.
REQ-026 SHALL decode loads/stores as ADD rs1_data + sign-extended I/S immediate.
REQ-027 SHALL decode branches: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU; operands rs1_data, rs2_data.
REQ-028 SHALL decode JAL/JALR as ADD with left pc and right 32'd4.
REQ-029 SHALL, for any other opcode or an R-type funct7 other than 0000000/0100000 (or 0100000 on a funct3 other than ADD/SRL), set illegal=1, control=ALU_ADD, both operands 0, and still issue the entry.
REQ-030 SHALL, on flush, clear out_valid and skid_valid next cycle and ignore any same-cycle input transfer.
REQ-031 SHALL give flush priority over simultaneous input/output transfers (the output transfer that cycle still counts as completed downstream).

Reset
REQ-032 SHALL, while reset is high, drive next-cycle out_valid=0, skid_valid=0, in_ready=1, control=ALU_ADD, operands 0, rd 0, illegal 0.
REQ-033 SHALL give reset priority over flush and all transfers; reset mid-stream discards buffered entries.

Verification
REQ-034 SHALL verify: reset, then R-type ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, control=ALU_ADD, left=5, right=7, rd=3.
REQ-035 SHALL verify: SRAI shamt 4 with rs1=0x80000000 → control=ALU_SRA, right=4; I-type ADDI imm 0xFFF → right=0xFFFFFFFF.
REQ-036 SHALL verify: back-to-back stream of 3 instructions, out_ready low 2 cycles after the first issues (SKID_EN=1) → in_ready drops after one extra accept, all 3 delivered in order, outputs stable while stalled.
REQ-037 SHALL verify: BLTU x1,x2 → control=ALU_SLTU; JAL at pc=0x100 → ALU_ADD, left=0x100, right=4; AUIPC imm 0x12345 at pc=0x10 → right=0x12345000, left=0x10.
REQ-038 SHALL verify: opcode 1111111 → illegal=1, control=ALU_ADD, operands 0.
REQ-039 SHALL verify: flush with both registers full and in_valid=1 → out_valid=0, in_ready=1 next cycle, no stale entry issued afterwards.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU issue stage: decode into an output register with optional skid buffer
module alu_issue_stage #(
  parameter int unsigned SKID_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  control,
  output logic [31:0] left_operand,
  output logic [31:0] right_operand,
  output logic [4:0]  rd,
  output logic        illegal
);

  // ALU operation codes shared with the execute stage
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // RV32I major opcodes
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam bit USE_SKID = (SKID_EN != 0);

  typedef struct packed {
    logic        illegal;
    logic [3:0]  control;
    logic [4:0]  rd;
    logic [31:0] left;
    logic [31:0] right;
  } issue_t;

  localparam issue_t EMPTY_ENTRY = '{illegal: 1'b0, control: ALU_ADD, rd: 5'd0,
                                     left: 32'd0, right: 32'd0};

  // Instruction fields and immediates
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'b0};
  assign shamt    = {27'd0, instr[24:20]};
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  logic [3:0] arith_ctrl;
  logic [3:0] branch_ctrl;
  logic       branch_ok;

  // funct3 to ALU operation for register and immediate arithmetic; funct7[5] picks SRA over SRL
  always_comb begin
    arith_ctrl = ALU_ADD;
    case (funct3)
      3'b000: arith_ctrl = ALU_ADD;
      3'b001: arith_ctrl = ALU_SLL;
      3'b010: arith_ctrl = ALU_SLT;
      3'b011: arith_ctrl = ALU_SLTU;
      3'b100: arith_ctrl = ALU_XOR;
      3'b101: arith_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: arith_ctrl = ALU_OR;
      3'b111: arith_ctrl = ALU_AND;
      default: arith_ctrl = ALU_ADD;
    endcase
  end

  // Branch compare selection: equality via SUB, signed and unsigned ordering via SLT/SLTU
  always_comb begin
    branch_ctrl = ALU_SUB;
    branch_ok   = 1'b1;
    case (funct3)
      3'b000, 3'b001: branch_ctrl = ALU_SUB;
      3'b100, 3'b101: branch_ctrl = ALU_SLT;
      3'b110, 3'b111: branch_ctrl = ALU_SLTU;
      default: begin
        branch_ctrl = ALU_ADD;
        branch_ok   = 1'b0;
      end
    endcase
  end

  issue_t dec;
  logic   dec_bad;

  // Full decode of the incoming instruction into an ALU request
  always_comb begin
    dec         = EMPTY_ENTRY;
    dec.rd      = instr[11:7];
    dec_bad     = 1'b0;
    case (opcode)
      OP_REG: begin
        dec.left  = rs1_data;
        dec.right = rs2_data;
        if (funct7 == F7_BASE) begin
          dec.control = arith_ctrl;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.control = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.control = ALU_SRA;
        end else begin
          dec_bad = 1'b1;
        end
      end
      OP_IMM: begin
        dec.control = arith_ctrl;
        dec.left    = rs1_data;
        dec.right   = is_shift ? shamt : imm_i;
      end
      OP_LUI: begin
        dec.left  = 32'd0;
        dec.right = imm_u;
      end
      OP_AUIPC: begin
        dec.left  = pc;
        dec.right = imm_u;
      end
      OP_LOAD: begin
        dec.left  = rs1_data;
        dec.right = imm_i;
      end
      OP_STORE: begin
        dec.left  = rs1_data;
        dec.right = imm_s;
      end
      OP_BRANCH: begin
        dec.control = branch_ctrl;
        dec.left    = rs1_data;
        dec.right   = rs2_data;
        dec_bad     = !branch_ok;
      end
      OP_JAL, OP_JALR: begin
        dec.left  = pc;
        dec.right = 32'd4;
      end
      default: dec_bad = 1'b1;
    endcase
    // Undecodable entries still issue, but as a harmless ADD of zeros
    if (dec_bad) begin
      dec.illegal = 1'b1;
      dec.control = ALU_ADD;
      dec.left    = 32'd0;
      dec.right   = 32'd0;
    end
  end

  // Buffering: output register plus an optional skid register behind it
  issue_t out_q;
  issue_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   in_xfer;
  logic   out_free;

  assign in_ready = USE_SKID ? !skid_valid_q : (!out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  // Output register refills from the skid entry first so ordering is preserved
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= EMPTY_ENTRY;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      if (USE_SKID && skid_valid_q) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
      end else if (in_xfer) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Skid register catches the one extra entry accepted while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_q       <= EMPTY_ENTRY;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      skid_valid_q <= 1'b0;
    end else if (USE_SKID && in_xfer) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign control       = out_q.control;
  assign left_operand  = out_q.left;
  assign right_operand = out_q.right;
  assign rd            = out_q.rd;
  assign illegal       = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd4;

  typedef struct packed {
    logic        illegal;
    logic [3:0]  control;
    logic [4:0]  rd;
    logic [31:0] left;
    logic [31:0] right;
  } exp_t;

  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  control;
  logic [31:0] left_operand;
  logic [31:0] right_operand;
  logic [4:0]  rd;
  logic        illegal;

  exp_t exp_cur;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.SKID_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .control(control), .left_operand(left_operand), .right_operand(right_operand),
    .rd(rd), .illegal(illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cmp_entry(input string tag, input exp_t got, input exp_t exp);
    check_eq({tag, ".illegal"}, 32'(got.illegal), 32'(exp.illegal));
    check_eq({tag, ".control"}, 32'(got.control), 32'(exp.control));
    check_eq({tag, ".rd"},      32'(got.rd),      32'(exp.rd));
    check_eq({tag, ".left"},    got.left,         exp.left);
    check_eq({tag, ".right"},   got.right,        exp.right);
  endtask

  function automatic exp_t mk(input logic il, input logic [3:0] c, input logic [4:0] r,
                              input logic [31:0] l, input logic [31:0] rt);
    exp_t e;
    e = {il, c, r, l, rt};
    return e;
  endfunction

  // Monitor: scoreboard push on input transfer, pop/compare on output transfer, stall stability
  exp_t obs;
  exp_t snap;
  exp_t popped;
  logic was_stalled = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      obs = {illegal, control, rd, left_operand, right_operand};
      if (reset) begin
        sb.delete();
        was_stalled = 1'b0;
      end else begin
        if (was_stalled) begin
          check_eq("stall_valid", 32'(out_valid), 32'd1);
          cmp_entry("stall_hold", obs, snap);
        end
        if (out_valid && out_ready) begin
          check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            popped = sb.pop_front();
            cmp_entry("issue", obs, popped);
          end
        end
        was_stalled = out_valid && !out_ready && !flush;
        snap = obs;
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(exp_cur);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    in_valid = 1'b1; instr = i; pc = p; rs1_data = a; rs2_data = b; exp_cur = e;
  endtask

  task automatic send(input vec_t v, output int waits);
    logic acc;
    logic done;
    waits = 0;
    done  = 1'b0;
    drive(v.i, v.p, v.a, v.b, v.e);
    while (!done) begin
      acc = in_ready;
      step();
      if (acc) done = 1'b1;
      else begin
        waits++;
        if (waits > 50) begin
          check_eq("send_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[11];
    vec_t va, vb, vc;
    int   w;
    int   total_w;
    int   n;

    v[0]  = '{32'h4040D293, 32'h0,   32'h80000000, 32'h0,  mk(1'b0, ALU_SRA,  5'd5,  32'h80000000, 32'd4)};
    v[1]  = '{32'hFFF08313, 32'h0,   32'h11,       32'h0,  mk(1'b0, ALU_ADD,  5'd6,  32'h11, 32'hFFFFFFFF)};
    v[2]  = '{32'h0020E063, 32'h40,  32'h3,        32'h9,  mk(1'b0, ALU_SLTU, 5'd0,  32'h3, 32'h9)};
    v[3]  = '{32'h000000EF, 32'h100, 32'hDEAD,     32'hBEEF, mk(1'b0, ALU_ADD, 5'd1, 32'h100, 32'd4)};
    v[4]  = '{32'h12345397, 32'h10,  32'h1,        32'h2,  mk(1'b0, ALU_ADD,  5'd7,  32'h10, 32'h12345000)};
    v[5]  = '{32'h0000047F, 32'h20,  32'h5,        32'h6,  mk(1'b1, ALU_ADD,  5'd8,  32'h0, 32'h0)};
    v[6]  = '{32'h40208233, 32'h0,   32'd10,       32'd3,  mk(1'b0, ALU_SUB,  5'd4,  32'd10, 32'd3)};
    v[7]  = '{32'h02208233, 32'h0,   32'd10,       32'd3,  mk(1'b1, ALU_ADD,  5'd4,  32'h0, 32'h0)};
    v[8]  = '{32'h0020A423, 32'h0,   32'h1000,     32'h55, mk(1'b0, ALU_ADD,  5'd8,  32'h1000, 32'd8)};
    v[9]  = '{32'hFFC0A483, 32'h0,   32'h2000,     32'h0,  mk(1'b0, ALU_ADD,  5'd9,  32'h2000, 32'hFFFFFFFC)};
    v[10] = '{32'hABCDE537, 32'h0,   32'h7,        32'h0,  mk(1'b0, ALU_ADD,  5'd10, 32'h0, 32'hABCDE000)};

    va = '{32'h002081B3, 32'h0, 32'd100, 32'd1, mk(1'b0, ALU_ADD, 5'd3, 32'd100, 32'd1)};
    vb = '{32'h40208233, 32'h0, 32'd50,  32'd8, mk(1'b0, ALU_SUB, 5'd4, 32'd50, 32'd8)};
    vc = v[10];

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; exp_cur = '0;

    // Reset state
    repeat (3) step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_control",   32'(control),   32'(ALU_ADD));
    check_eq("rst_left",      left_operand,   32'd0);
    check_eq("rst_right",     right_operand,  32'd0);
    check_eq("rst_rd",        32'(rd),        32'd0);
    check_eq("rst_illegal",   32'(illegal),   32'd0);
    reset = 1'b0;
    step();

    // ADD x3,x1,x2 with one-cycle latency
    out_ready = 1'b1;
    send('{32'h002081B3, 32'h0, 32'd5, 32'd7, mk(1'b0, ALU_ADD, 5'd3, 32'd5, 32'd7)}, w);
    in_valid = 1'b0;
    check_eq("add_latency", 32'(out_valid), 32'd1);
    step();

    // Back-to-back decode table at full throughput
    total_w = 0;
    for (int k = 0; k < 11; k++) begin
      send(v[k], w);
      total_w += w;
    end
    in_valid = 1'b0;
    check_eq("stream_waits", 32'(total_w), 32'd0);
    step();

    // Stall with skid: one extra accept, then in_ready drops
    drive(va.i, va.p, va.a, va.b, va.e);
    check_eq("stall_acc_a", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    drive(vb.i, vb.p, vb.a, vb.b, vb.e);
    check_eq("stall_acc_b", 32'(in_ready), 32'd1);
    step();
    drive(vc.i, vc.p, vc.a, vc.b, vc.e);
    check_eq("stall_drop", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    check_eq("stall_release", 32'(in_ready), 32'd0);
    check_eq("stall_out_a", left_operand, 32'd100);
    step();
    check_eq("stall_reopen", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();
    step();

    // Flush with out and skid full and in_valid high
    out_ready = 1'b0;
    send(va, w);
    send(vb, w);
    drive(vc.i, vc.p, vc.a, vc.b, vc.e);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("flush_no_stale", 32'(out_valid), 32'd0);
    end

    // Flush ignores a same-cycle input transfer into an empty stage
    drive(va.i, va.p, va.a, va.b, va.e);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_drop_in", 32'(out_valid), 32'd0);
    step();

    // Stage resumes after flush
    send(vb, w);
    in_valid = 1'b0;
    check_eq("post_flush_issue", 32'(out_valid), 32'd1);
    step();

    // Reset mid-stream discards buffered entries
    out_ready = 1'b0;
    send(va, w);
    send(vb, w);
    drive(vc.i, vc.p, vc.a, vc.b, vc.e);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_in_ready",  32'(in_ready),  32'd1);
    check_eq("rst_mid_left",      left_operand,   32'd0);
    out_ready = 1'b1;
    step();
    check_eq("rst_mid_no_stale", 32'(out_valid), 32'd0);

    // Drain scoreboard
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    step();
    check_eq("drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
